// File: rtl/nibble_lane_packer.sv
// Packs a stream of LW-bit nibbles, first nibble into lane 0, into OUTW-bit words on a registered valid/ready output.
// Optional partial-word flush is compiled in with NIBBLE_LANE_PACKER_FLUSH_EN.
module nibble_lane_packer #(
    parameter int NLANES = 8,
    parameter int LW     = 4,
    parameter int OUTW   = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LW-1:0]                 in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUTW-1:0]               out_data,
    output logic [$clog2(NLANES+1)-1:0]   out_len,
    input  logic                          flush
);

    localparam int IDXW = $clog2(NLANES);
    localparam int LENW = $clog2(NLANES + 1);
    localparam int ACCW = NLANES * LW;

    logic [IDXW-1:0] idx_r;
    logic [ACCW-1:0] acc_r;
    logic            out_valid_r;
    logic [OUTW-1:0] out_data_r;
    logic [LENW-1:0] out_len_r;

    logic            slot_free_s;
    logic            last_s;
    logic            in_fire_s;
    logic            flush_go_s;
    logic            load_s;
    logic [ACCW-1:0] acc_fill_s;
    logic [LENW-1:0] fill_len_s;
    logic [OUTW-1:0] word_s;
    logic [IDXW-1:0] idx_next_s;
    logic [ACCW-1:0] acc_next_s;
    logic            out_valid_next_s;
    logic [OUTW-1:0] out_data_next_s;
    logic [LENW-1:0] out_len_next_s;

`ifndef NIBBLE_LANE_PACKER_FLUSH_EN
    logic unused_flush_s;
    assign unused_flush_s = flush;
`endif

    // The last lane may only be taken when the output register can receive the word.
    assign in_ready = (!last_s) || slot_free_s;

    // Handshake decode, lane fill and next-state selection.
    always_comb begin
        slot_free_s = (!out_valid_r) || out_ready;
        last_s      = (idx_r == IDXW'(NLANES - 1));
        in_fire_s   = in_valid && ((!last_s) || slot_free_s);

        acc_fill_s = acc_r;
        for (int k = 0; k < NLANES; k++) begin
            if (in_fire_s && (idx_r == IDXW'(k))) begin
                acc_fill_s[k*LW +: LW] = in_data;
            end else begin
                acc_fill_s[k*LW +: LW] = acc_r[k*LW +: LW];
            end
        end

`ifdef NIBBLE_LANE_PACKER_FLUSH_EN
        flush_go_s = flush && slot_free_s && ((idx_r != {IDXW{1'b0}}) || in_fire_s);
        fill_len_s = LENW'(idx_r) + (in_fire_s ? LENW'(1) : LENW'(0));
`else
        flush_go_s = 1'b0;
        fill_len_s = LENW'(NLANES);
`endif

        load_s = (in_fire_s && last_s) || flush_go_s;

        // Unfilled lanes of acc are always zero, so a flushed word needs no masking.
        word_s            = {OUTW{1'b0}};
        word_s[ACCW-1:0]  = acc_fill_s;

        if (load_s) begin
            idx_next_s       = {IDXW{1'b0}};
            acc_next_s       = {ACCW{1'b0}};
            out_valid_next_s = 1'b1;
            out_data_next_s  = word_s;
            out_len_next_s   = fill_len_s;
        end else begin
            idx_next_s       = in_fire_s ? (idx_r + IDXW'(1)) : idx_r;
            acc_next_s       = acc_fill_s;
            out_valid_next_s = out_ready ? 1'b0 : out_valid_r;
            out_data_next_s  = out_data_r;
            out_len_next_s   = out_len_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= {IDXW{1'b0}};
            acc_r       <= {ACCW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {OUTW{1'b0}};
            out_len_r   <= {LENW{1'b0}};
        end else begin
            idx_r       <= idx_next_s;
            acc_r       <= acc_next_s;
            out_valid_r <= out_valid_next_s;
            out_data_r  <= out_data_next_s;
            out_len_r   <= out_len_next_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_len   = out_len_r;

endmodule

// File: tb/tb_nibble_lane_packer.sv
// Table-driven directed bench for nibble_lane_packer (NLANES=8, LW=4, OUTW=128).
module tb_nibble_lane_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_data = 4'h0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic [3:0]   out_len;
    logic         flush = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         iv;
        logic [3:0]   d;
        logic         ordy;
        logic         fl;
        logic         e_ir;
        logic         e_ov;
        logic [127:0] e_data;
        logic [3:0]   e_len;
    } vec_t;

    vec_t tv[$];

    nibble_lane_packer #(.NLANES(8), .LW(4), .OUTW(128)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_len   (out_len),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    task automatic add(input logic iv, input logic [3:0] d, input logic ordy, input logic fl,
                       input logic e_ir, input logic e_ov, input logic [127:0] e_data,
                       input logic [3:0] e_len);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data; v.e_len = e_len;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next edge.
    task automatic step(input vec_t v);
        in_valid  = v.iv;
        in_data   = v.d;
        out_ready = v.ordy;
        flush     = v.fl;
        #1;
        check("in_ready", {127'd0, in_ready}, {127'd0, v.e_ir});
        @(posedge clk);
        #1;
        check("out_valid", {127'd0, out_valid}, {127'd0, v.e_ov});
        if (v.e_ov) begin
            check("out_data", out_data, v.e_data);
            check("out_len", {124'd0, out_len}, {124'd0, v.e_len});
        end
    endtask

    task automatic run_table();
        foreach (tv[i]) step(tv[i]);
        tv.delete();
    endtask

    initial begin
        logic [127:0] w;
        logic [3:0]   nib;

        // Reset state
        #12;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_len", {124'd0, out_len}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic word 1..8, single-cycle out_valid
        for (int k = 0; k < 8; k++)
            add(1'b1, 4'(k + 1), 1'b1, 1'b0, 1'b1, (k == 7), 128'h87654321, 4'd8);
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 4'd0);

        // Backpressure: word of F held, next word fills lanes 0..6, stalls at lane 7
        for (int k = 0; k < 8; k++)
            add(1'b1, 4'hF, 1'b0, 1'b0, 1'b1, (k == 7), 128'hFFFFFFFF, 4'd8);
        for (int k = 0; k < 7; k++)
            add(1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 128'hFFFFFFFF, 4'd8);
        add(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 128'hFFFFFFFF, 4'd8);
        add(1'b1, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1, 128'hFFFFFFFF, 4'd8);
        add(1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 128'hAAAAAAAA, 4'd8);
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 4'd0);

        // Continuous streaming: 3 words, out_valid exactly every 8th cycle
        for (int j = 0; j < 3; j++) begin
            w = 128'd0;
            for (int k = 0; k < 8; k++) begin
                nib = 4'(j * 3 + k + 1);
                w[k*4 +: 4] = nib;
            end
            for (int k = 0; k < 8; k++) begin
                nib = w[k*4 +: 4];
                add(1'b1, nib, 1'b1, 1'b0, 1'b1, (k == 7), w, 4'd8);
            end
        end
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 4'd0);

        // Hold a word of 3s, then 5 nibbles of the next word before reset
        for (int k = 0; k < 8; k++)
            add(1'b1, 4'h3, 1'b0, 1'b0, 1'b1, (k == 7), 128'h33333333, 4'd8);
        for (int k = 0; k < 5; k++)
            add(1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1, 128'h33333333, 4'd8);
        run_table();

        // Asynchronous reset mid-word with a held output word
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("async_rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("async_rst_out_data", out_data, 128'd0);
        check("async_rst_in_ready", {127'd0, in_ready}, 128'd1);
        #2;
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++)
            add(1'b1, 4'(9 - k), 1'b1, 1'b0, 1'b1, (k == 7), 128'h23456789, 4'd8);
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 4'd0);

`ifdef NIBBLE_LANE_PACKER_FLUSH_EN
        // Partial word flushed together with a same-cycle nibble, then a no-op flush at lane 0
        add(1'b1, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 4'd0);
        add(1'b1, 4'hC, 1'b1, 1'b0, 1'b1, 1'b0, 128'd0, 4'd0);
        add(1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 128'h5C3, 4'd3);
        add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 128'd0, 4'd0);
        add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 128'd0, 4'd0);
`else
        // flush toggling during a word has no effect
        for (int k = 0; k < 8; k++)
            add(1'b1, 4'(8 - k), 1'b1, 1'(k % 2), 1'b1, (k == 7), 128'h12345678, 4'd8);
        add(1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 128'd0, 4'd0);
`endif
        run_table();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_lane_packer.md
Name: nibble_lane_packer

Overview:
- Upstream feeder for the nibble-lane instance array, which takes a 128-bit bus and splits bits [31:0] into eight 4-bit lanes, lane k = bits [4k+3:4k].
- This block accepts a serial stream of 4-bit nibbles over a valid/ready handshake and assembles them in lane order, first nibble into lane 0.
- It presents each completed 128-bit word on a registered valid/ready output. Bits above NLANES*LW are zero.

Parameters:
- NLANES, 8, number of nibble lanes per word (range 2..32, NLANES*LW <= OUTW).
- LW, 4, lane width in bits.
- OUTW, 128, output bus width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  LW  nibble for the next lane.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  OUTW  packed word; lane k at [k*LW +: LW]; bits [OUTW-1:NLANES*LW] are always 0.
- out_len  output  $clog2(NLANES+1)  number of filled lanes in out_data.
- flush  input  1  emit a partial word (active only with the optional feature).

Behaviour:
- State:
  - idx: lane index, 0..NLANES-1.
  - acc: NLANES*LW accumulator.
  - obuf: output register, with out_valid and out_len.
- Reset (rst_n low, asynchronous, any cycle including mid-word):
  - idx=0, acc=0, out_valid=0, out_data=0, out_len=0.
  - Any partially assembled word and any held output word are discarded.
  - Deassertion is sampled synchronously; the first accept is possible on the first edge after rst_n rises.
- Accept: in_fire = in_valid & in_ready.
- slot_free = !out_valid | out_ready. The output register is empty or being drained this cycle.
- in_ready = (idx != NLANES-1) | slot_free. This is combinational from registers and out_ready, with no path from in_valid.
- in_fire with idx < NLANES-1:
  - acc lane idx <= in_data; idx <= idx+1.
  - The output register is unaffected.
- in_fire with idx == NLANES-1 (word completes):
  - obuf <= {zero pad, in_data, acc lanes NLANES-2..0}.
  - out_valid <= 1; out_len <= NLANES.
  - idx <= 0; acc <= 0.
- out_valid & out_ready with no new word loaded in that cycle: out_valid <= 0. out_data holds its value; its contents are don't-care while out_valid=0.
- Simultaneous drain and load in the same cycle: the new word replaces the old. out_valid stays 1, giving a back-to-back word with no bubble.
- Latency: the last nibble accepted at edge N gives out_valid=1 after edge N. A word can be presented every NLANES accepts.
- Backpressure:
  - While out_valid=1 and out_ready=0, the block still accepts lanes 0..NLANES-2 of the next word.
  - It stalls (in_ready=0) only at idx==NLANES-1.
- Stability: while out_valid=1 and out_ready=0, out_data and out_len hold.
- No overflow path exists, and no input nibble is ever dropped.

Optional Feature:
- Macro: NIBBLE_LANE_PACKER_FLUSH_EN.
- Defined:
  - flush is sampled on cycles where slot_free=1.
  - If (idx != 0) or in_fire, the current partial word goes to obuf.
    - A nibble accepted in the same cycle is included.
    - Unfilled lanes are 0.
    - out_len = filled lane count.
    - idx <= 0, acc <= 0.
  - A full completion in the same cycle takes precedence (out_len = NLANES) and is identical.
  - flush with idx==0 and no in_fire: no effect.
  - flush while slot_free=0: ignored that cycle. The source holds flush until out_valid rises.
- Undefined:
  - The flush port exists but is ignored.
  - out_len is constant NLANES whenever out_valid=1.

Test Plan:
- Reset, then 8 accepts of nibbles 1,2,3,4,5,6,7,8 with out_ready=1 -> after the 8th edge, out_valid=1 for 1 cycle, out_data=128'h87654321, out_len=8.
- out_ready=0; send word A (nibbles 0..7 = 0xF) then 7 nibbles 0xA -> out_data holds 128'hFFFFFFFF; in_ready=0 at idx=7. Raise out_ready -> 8th 0xA accepted in the same cycle; next out_data=128'hAAAAAAAA with no out_valid gap.
- Continuous in_valid and out_ready=1 for 3 words -> out_valid pulses exactly every 8 cycles; word count matches with no loss.
- Assert rst_n=0 asynchronously after 5 nibbles with a word held in obuf -> out_valid=0 immediately, without waiting for a clock edge. After release, nibbles 9,8,7,6,5,4,3,2 -> 128'h23456789.
- (FLUSH_EN) Accept 3,C, then flush with nibble 5 in the same cycle -> out_data=128'h5C3, out_len=3. flush at idx=0 -> no out_valid.
- (no FLUSH_EN) flush toggling during a word -> no effect; out_len=8 on every word.
